// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch predictor types and default widths
package branch_pkg;

    // Defaults shared with the gshare predictor.
    localparam int BP_ADDR_W = 11;
    localparam int BP_GHR_W  = 4;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } state_t;

    // One in-flight prediction at the default widths.
    typedef struct packed {
        logic [BP_ADDR_W-1:0] addr;
        logic [BP_GHR_W-1:0]  ghr;
        logic                 pred_taken;
    } entry_t;

endpackage

// File: rtl/bot_fifo.sv
// rtl/bot_fifo.sv - circular buffer holding in-flight predictions
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_data     write push_data at tail (caller guarantees !full)
//   pop                 advance head (caller guarantees !empty)
//   clear               drop all entries; overrides push and pop
//   head_data           oldest entry
//   occupancy           entries held, 0..DEPTH
//   full, empty         occupancy flags
module bot_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (clear) begin
            // Collapse onto the tail; a same-cycle push is wrong-path and lost.
            head <= tail;
            occ  <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Payload needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear && !reset) mem[tail] <= push_data;
    end

    assign head_data = mem[head];
    assign occupancy = occ;
    assign full      = (occ == FULL_OCC);
    assign empty     = (occ == '0);

endmodule

// File: rtl/branch_outcome_tracker.sv
// rtl/branch_outcome_tracker.sv - in-order prediction tracker, update/flush generator and accuracy counters
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   pred_valid/addr/ghr/taken, pred_ready   prediction enqueue handshake
//   res_valid, res_taken                resolution of the oldest branch
//   upd_valid/addr/ghr/taken            registered pattern table update pulse
//   mispredict                          registered flush pulse
//   occupancy                           entries in flight
//   res_error                           sticky: resolve seen with nothing in flight
//   branch_cnt, mispred_cnt             saturating statistics
module branch_outcome_tracker
    import branch_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W,
    parameter int GHR_W  = BP_GHR_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_addr,
    input  logic [GHR_W-1:0]  pred_ghr,
    input  logic              pred_taken,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [GHR_W-1:0]  upd_ghr,
    output logic              upd_taken,
    output logic              mispredict,
    output logic [OCC_W-1:0]  occupancy,
    output logic              res_error,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int ENTRY_W = ADDR_W + GHR_W + 1;

    state_t             state;
    state_t             state_next;
    logic [ENTRY_W-1:0] head_data;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               mis;
    logic               err_set;

    logic [ADDR_W-1:0]  head_addr;
    logic [GHR_W-1:0]   head_ghr;
    logic               head_taken;

    assign head_addr  = head_data[ENTRY_W-1 -: ADDR_W];
    assign head_ghr   = head_data[GHR_W:1];
    assign head_taken = head_data[0];

    bot_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({pred_addr, pred_ghr, pred_taken}),
        .pop       (pop),
        .clear     (mis),
        .head_data (head_data),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= NORMAL;
        else       state <= state_next;
    end

    // Readiness uses pre-pop fullness, so a push while full is dropped even
    // when the head pops in the same cycle. RECOVER ignores resolves entirely.
    always_comb begin
        state_next = state;
        pred_ready = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        mis        = 1'b0;
        err_set    = 1'b0;
        case (state)
            NORMAL: begin
                pred_ready = !full;
                push       = pred_valid && !full;
                pop        = res_valid && !empty;
                err_set    = res_valid && empty;
                mis        = pop && (head_taken != res_taken);
                if (mis) state_next = RECOVER;
            end
            RECOVER: begin
                state_next = NORMAL;
            end
            default: begin
                state_next = NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid   <= 1'b0;
            upd_addr    <= '0;
            upd_ghr     <= '0;
            upd_taken   <= 1'b0;
            mispredict  <= 1'b0;
            res_error   <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            upd_valid  <= pop;
            mispredict <= mis;
            if (pop) begin
                upd_addr  <= head_addr;
                upd_ghr   <= head_ghr;
                upd_taken <= res_taken;
                if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mis && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
            if (err_set) res_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// tb/tb_branch_outcome_tracker.sv - self-checking bench for branch_outcome_tracker
module tb_branch_outcome_tracker;
    import branch_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [10:0] pred_addr;
    logic [3:0]  pred_ghr;
    logic        pred_taken;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        upd_valid;
    logic [10:0] upd_addr;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        mispredict;
    logic [3:0]  occupancy;
    logic        res_error;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    logic        pred_ready2;
    logic        upd_valid2;
    logic [10:0] upd_addr2;
    logic [3:0]  upd_ghr2;
    logic        upd_taken2;
    logic        mispredict2;
    logic [3:0]  occupancy2;
    logic        res_error2;
    logic [1:0]  branch_cnt2;
    logic [1:0]  mispred_cnt2;

    always #5 clk = ~clk;

    branch_outcome_tracker dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_ghr(pred_ghr),
        .pred_taken(pred_taken), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .mispredict(mispredict), .occupancy(occupancy),
        .res_error(res_error), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_outcome_tracker #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_ghr(pred_ghr),
        .pred_taken(pred_taken), .pred_ready(pred_ready2),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid2), .upd_addr(upd_addr2), .upd_ghr(upd_ghr2),
        .upd_taken(upd_taken2), .mispredict(mispredict2), .occupancy(occupancy2),
        .res_error(res_error2), .branch_cnt(branch_cnt2), .mispred_cnt(mispred_cnt2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of in-flight predictions plus the
    // observable results of the last clock edge.
    entry_t      mq[$];
    bit          m_rec;
    bit          m_err;
    bit          m_uv;
    bit          m_mp;
    bit          m_ut;
    logic [10:0] m_ua;
    logic [3:0]  m_ug;
    int          m_bc;
    int          m_mc;

    function automatic int sat(input int n, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    task automatic model_edge();
        entry_t h;
        bit     popped;
        bit     wrong;
        bit     rdy;
        if (reset) begin
            mq.delete();
            m_rec = 0; m_err = 0; m_uv = 0; m_mp = 0; m_ut = 0;
            m_ua = '0; m_ug = '0; m_bc = 0; m_mc = 0;
        end else begin
            popped = 0;
            wrong  = 0;
            rdy    = !m_rec && (mq.size() < DEPTH);
            if (!m_rec && res_valid) begin
                if (mq.size() == 0) begin
                    m_err = 1;
                end else begin
                    h      = mq.pop_front();
                    popped = 1;
                    wrong  = (h.pred_taken != res_taken);
                    m_ua   = h.addr;
                    m_ug   = h.ghr;
                    m_ut   = res_taken;
                    m_bc++;
                    if (wrong) m_mc++;
                end
            end
            if (wrong) mq.delete();
            else if (pred_valid && rdy) mq.push_back('{pred_addr, pred_ghr, pred_taken});
            m_uv  = popped;
            m_mp  = wrong;
            m_rec = wrong;
        end
    endtask

    task automatic check_all();
        chk("upd_valid",   upd_valid,   m_uv);
        chk("mispredict",  mispredict,  m_mp);
        chk("upd_addr",    upd_addr,    m_ua);
        chk("upd_ghr",     upd_ghr,     m_ug);
        chk("upd_taken",   upd_taken,   m_ut);
        chk("occupancy",   occupancy,   mq.size());
        chk("pred_ready",  pred_ready,  !m_rec && (mq.size() < DEPTH));
        chk("res_error",   res_error,   m_err);
        chk("branch_cnt",  branch_cnt,  sat(m_bc, 16));
        chk("mispred_cnt", mispred_cnt, sat(m_mc, 16));
        chk("branch_cnt_w2",  branch_cnt2,  sat(m_bc, 2));
        chk("mispred_cnt_w2", mispred_cnt2, sat(m_mc, 2));
    endtask

    task automatic step(input bit pv, input logic [10:0] a, input logic [3:0] g,
                        input bit t, input bit rv, input bit rt, input bit rs);
        reset      = rs;
        pred_valid = pv;
        pred_addr  = a;
        pred_ghr   = g;
        pred_taken = t;
        res_valid  = rv;
        res_taken  = rt;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        bit          rs;
        bit          pv;
        logic [10:0] a;
        logic [3:0]  g;
        bit          t;
        bit          rv;
        bit          rt;
        bit          e_uv;
        bit          e_mp;
        int          e_occ;
        bit          e_rdy;
        logic [10:0] e_addr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rs, bit pv, logic [10:0] a, logic [3:0] g, bit t,
                                bit rv, bit rt, bit e_uv, bit e_mp, int e_occ,
                                bit e_rdy, logic [10:0] e_addr);
        vec_t v;
        v.rs = rs; v.pv = pv; v.a = a; v.g = g; v.t = t; v.rv = rv; v.rt = rt;
        v.e_uv = e_uv; v.e_mp = e_mp; v.e_occ = e_occ; v.e_rdy = e_rdy; v.e_addr = e_addr;
        return v;
    endfunction

    initial begin
        reset = 1'b1; pred_valid = 0; pred_addr = '0; pred_ghr = '0;
        pred_taken = 0; res_valid = 0; res_taken = 0;

        //             rs pv addr    ghr  t  rv rt  uv mp occ rdy addr
        vt.push_back(mk(1, 0, 11'h000, 4'h0, 0, 0, 0,  0, 0, 0, 1, 11'h000));
        vt.push_back(mk(0, 1, 11'h012, 4'h3, 1, 0, 0,  0, 0, 1, 1, 11'h000));
        vt.push_back(mk(0, 0, 11'h000, 4'h0, 0, 1, 1,  1, 0, 0, 1, 11'h012));
        vt.push_back(mk(0, 1, 11'h100, 4'h1, 0, 0, 0,  0, 0, 1, 1, 11'h000));
        vt.push_back(mk(0, 1, 11'h101, 4'h2, 0, 0, 0,  0, 0, 2, 1, 11'h000));
        vt.push_back(mk(0, 1, 11'h102, 4'h4, 1, 0, 0,  0, 0, 3, 1, 11'h000));
        vt.push_back(mk(0, 0, 11'h000, 4'h0, 0, 1, 1,  1, 1, 0, 0, 11'h100));
        vt.push_back(mk(0, 0, 11'h000, 4'h0, 0, 0, 0,  0, 0, 0, 1, 11'h000));
        vt.push_back(mk(1, 0, 11'h000, 4'h0, 0, 0, 0,  0, 0, 0, 1, 11'h000));
        vt.push_back(mk(0, 0, 11'h000, 4'h0, 0, 1, 0,  0, 0, 0, 1, 11'h000));
        vt.push_back(mk(0, 1, 11'h055, 4'h5, 0, 1, 0,  0, 0, 1, 1, 11'h000));
        vt.push_back(mk(0, 0, 11'h000, 4'h0, 0, 1, 0,  1, 0, 0, 1, 11'h055));

        foreach (vt[i]) begin
            step(vt[i].pv, vt[i].a, vt[i].g, vt[i].t, vt[i].rv, vt[i].rt, vt[i].rs);
            chk($sformatf("vec%0d_upd_valid", i),  upd_valid,  vt[i].e_uv);
            chk($sformatf("vec%0d_mispredict", i), mispredict, vt[i].e_mp);
            chk($sformatf("vec%0d_occupancy", i),  occupancy,  vt[i].e_occ);
            chk($sformatf("vec%0d_pred_ready", i), pred_ready, vt[i].e_rdy);
            if (vt[i].e_uv) chk($sformatf("vec%0d_upd_addr", i), upd_addr, vt[i].e_addr);
        end
        chk("res_error_sticky", res_error, 1'b1);

        // Fill to capacity after moving the pointers, so the fill wraps.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 11'h050 + 11'(i), 4'(i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 11'h200 + 11'(i), 4'(i), i[0], 0, 0, 0);
        chk("full_occupancy", occupancy, 8);
        chk("full_ready", pred_ready, 1'b0);
        step(1, 11'h2ff, 4'hf, 0, 0, 0, 0);
        chk("ninth_dropped", occupancy, 8);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 1, i[0], 0);
            chk($sformatf("drain%0d_addr", i), upd_addr, 11'h200 + 11'(i));
            chk($sformatf("drain%0d_mis", i), mispredict, 1'b0);
        end

        // Same-cycle push and resolve at occupancy 4.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 11'h300 + 11'(i), 4'h0, 1, 0, 0, 0);
        step(1, 11'h304, 4'h0, 1, 1, 1, 0);
        chk("push_pop_occ", occupancy, 4);
        step(1, 11'h305, 4'h0, 1, 1, 0, 0);
        chk("push_mis_occ", occupancy, 0);
        chk("push_mis_pulse", mispredict, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0);

        // Saturation of the narrow counters.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 11'h400 + 11'(i), 4'h0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0, 0, 0);
        end
        chk("sat_branch_w2", branch_cnt2, 2'd3);
        chk("sat_mispred_w2", mispred_cnt2, 2'd3);
        chk("wide_branch", branch_cnt, 16'd5);

        // Reset mid-stream with a resolve pending.
        step(1, 11'h500, 4'h1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 1);
        chk("rst_upd_valid", upd_valid, 1'b0);
        chk("rst_occ", occupancy, 0);
        chk("rst_branch_cnt", branch_cnt, 16'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, 11'($urandom), 4'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 4, 1'($urandom), $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
